// File: rtl/mux_sel_scanner_if.sv
// Bus bundle between mux_sel_scanner and its 4:1 mux / consumer.
// The parity signal exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_sel_scanner_if;
  logic       start;
  logic       cont;
  logic [3:0] ch_mask;
  logic       s0;
  logic       s1;
  logic       mux_in;
  logic [3:0] sample;
  logic       valid;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity;

  modport master (
    output start, cont, ch_mask, mux_in,
    input  s0, s1, sample, valid, busy, parity
  );
  modport slave (
    input  start, cont, ch_mask, mux_in,
    output s0, s1, sample, valid, busy, parity
  );
`else
  modport master (
    output start, cont, ch_mask, mux_in,
    input  s0, s1, sample, valid, busy
  );
  modport slave (
    input  start, cont, ch_mask, mux_in,
    output s0, s1, sample, valid, busy
  );
`endif
endinterface

// File: rtl/mux_sel_scanner.sv
// Steps a 4:1 mux through enabled channels, samples each after a settle delay and emits
// one 4-bit snapshot per sweep. Define MUX_SCAN_PARITY_EN to add a registered parity output.
module mux_sel_scanner #(
  parameter int unsigned DWELL  = 4,
  parameter int unsigned SETTLE = 2
) (
  input logic               clk,
  input logic               rst_n,
  mux_sel_scanner_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DWELL);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      shadow_q, shadow_d;
  logic [3:0]      sample_q, sample_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            nxt_found;
  logic [1:0]      nxt_ch;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next enabled channel above the current one; descending loop so the nearest wins.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = ch_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = 2'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && (bus.ch_mask != 4'd0)) begin
          mask_d   = bus.ch_mask;
          shadow_d = 4'd0;
          ch_d     = lowest_ch(bus.ch_mask);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StScan;
        end
      end
      StScan: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(SETTLE)) shadow_d[ch_q] = bus.mux_in;
        if (cnt_q == CntW'(DWELL - 1)) begin
          cnt_d = '0;
          if (nxt_found) begin
            ch_d = nxt_ch;
          end else begin
            // shadow_d already carries a same-edge sample of the last channel
            sample_d = shadow_d & mask_q;
            valid_d  = 1'b1;
            if (bus.cont && (bus.ch_mask != 4'd0)) begin
              mask_d   = bus.ch_mask;
              shadow_d = 4'd0;
              ch_d     = lowest_ch(bus.ch_mask);
            end else begin
              busy_d  = 1'b0;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ch_q     <= 2'd0;
      cnt_q    <= '0;
      mask_q   <= 4'd0;
      shadow_q <= 4'd0;
      sample_q <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.s1     = ch_q[1];
  assign bus.s0     = ch_q[0];
  assign bus.sample = sample_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;

`ifdef MUX_SCAN_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^sample_d;
    end
  end

  assign bus.parity = parity_q;
`endif

endmodule
